// File: rtl/decode_regfile.sv
// Decode / register-read stage: 16x16 register file, instruction decode,
// registered ID/EX boundary, RAW interlock and wrong-path squash.
module decode_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic [7:0]  pc_in,
   input  logic        instr_valid,
   input  logic [15:0] wdata_e,
   input  logic [3:0]  dest_e,
   input  logic        we_e,
   input  logic        bj,
   output logic [15:0] do1,
   output logic [15:0] do2,
   output logic [15:0] imm,
   output logic [3:0]  dest,
   output logic [1:0]  alucnt,
   output logic        sel,
   output logic        wes,
   output logic [7:0]  disp8,
   output logic [7:0]  nxtadrsrr,
   output logic [1:0]  branchs,
   output logic        stall
);

   logic [15:0] regs [16];

   logic [3:0]  op;
   logic        is_alu;
   logic        is_li;
   logic        is_br;
   logic        reads;
   logic [3:0]  src_a;
   logic [3:0]  src_b;
   logic [15:0] rdata_a;
   logic [15:0] rdata_b;
   logic        hazard;
   logic        issue;

   logic [15:0] n_do1;
   logic [15:0] n_do2;
   logic [15:0] n_imm;
   logic [3:0]  n_dest;
   logic [1:0]  n_alucnt;
   logic        n_sel;
   logic        n_wes;
   logic [7:0]  n_disp8;
   logic [7:0]  n_nxt;
   logic [1:0]  n_branchs;

   assign op     = instr[15:12];
   assign is_alu = (op[3:2] == 2'b00);
   assign is_li  = (op == 4'h4);
   assign is_br  = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
   assign reads  = is_alu || is_br;

   // ALU ops take sources from [7:4]/[3:0]; branches from [11:8]/[7:4].
   assign src_a = is_alu ? instr[7:4] : instr[11:8];
   assign src_b = is_alu ? instr[3:0] : instr[7:4];

   // R0 is hardwired zero; a same-cycle write-back is forwarded.
   assign rdata_a = (src_a == 4'd0) ? 16'h0000 :
                    (we_e && dest_e == src_a) ? wdata_e :
                    regs[src_a];
   assign rdata_b = (src_b == 4'd0) ? 16'h0000 :
                    (we_e && dest_e == src_b) ? wdata_e :
                    regs[src_b];

   // Producer still in ID/EX: its result is not yet in the file.
   assign hazard = instr_valid && reads && wes && (dest != 4'd0) &&
                   (dest == src_a || dest == src_b);

   // A squashed instruction never needs to wait.
   assign stall = hazard && !bj;

   assign issue = instr_valid && !bj && !hazard &&
                  (is_alu || is_li || is_br);

   // Register file write port; R0 writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      end else if (we_e && dest_e != 4'd0) begin
         regs[dest_e] <= wdata_e;
      end
   end

   // Decode the instruction into next ID/EX control values.
   always_comb begin
      n_do1     = 16'h0000;
      n_do2     = 16'h0000;
      n_imm     = {8'h00, instr[7:0]};
      n_dest    = 4'd0;
      n_alucnt  = 2'b00;
      n_sel     = 1'b0;
      n_wes     = 1'b0;
      n_disp8   = 8'h00;
      n_nxt     = pc_in + 8'd1;
      n_branchs = 2'b00;
      unique case (1'b1)
         is_alu: begin
            n_do1    = rdata_a;
            n_do2    = rdata_b;
            n_dest   = instr[11:8];
            n_alucnt = op[1:0];
            n_wes    = 1'b1;
         end
         is_li: begin
            n_dest = instr[11:8];
            n_sel  = 1'b1;
            n_wes  = 1'b1;
         end
         is_br: begin
            n_do1     = rdata_a;
            n_do2     = rdata_b;
            n_disp8   = {{4{instr[3]}}, instr[3:0]};
            n_branchs = (op == 4'h8) ? 2'b01 :
                        (op == 4'h9) ? 2'b10 : 2'b11;
         end
         default: ;
      endcase
   end

   // ID/EX boundary: load the decode or a bubble.
   always_ff @(posedge clk) begin
      if (rst || !issue) begin
         do1       <= 16'h0000;
         do2       <= 16'h0000;
         imm       <= 16'h0000;
         dest      <= 4'd0;
         alucnt    <= 2'b00;
         sel       <= 1'b0;
         wes       <= 1'b0;
         disp8     <= 8'h00;
         nxtadrsrr <= 8'h00;
         branchs   <= 2'b00;
      end else begin
         do1       <= n_do1;
         do2       <= n_do2;
         imm       <= n_imm;
         dest      <= n_dest;
         alucnt    <= n_alucnt;
         sel       <= n_sel;
         wes       <= n_wes;
         disp8     <= n_disp8;
         nxtadrsrr <= n_nxt;
         branchs   <= n_branchs;
      end
   end

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: per-cycle vector table, expected ID/EX
// contents queued at drive time and compared after the clock edge.
module tb_decode_regfile;

   typedef struct packed {
      logic [15:0] do1;
      logic [15:0] do2;
      logic [15:0] imm;
      logic [3:0]  dest;
      logic [1:0]  alucnt;
      logic        sel;
      logic        wes;
      logic [7:0]  disp8;
      logic [7:0]  nxt;
      logic [1:0]  branchs;
   } out_t;

   typedef struct {
      logic        rst;
      logic [15:0] instr;
      logic [7:0]  pc;
      logic        valid;
      logic        we;
      logic [3:0]  de;
      logic [15:0] wd;
      logic        bj;
      logic        chk_stall;
      logic        stall;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic [7:0]  pc_in;
   logic        instr_valid;
   logic [15:0] wdata_e;
   logic [3:0]  dest_e;
   logic        we_e;
   logic        bj;
   logic [15:0] do1;
   logic [15:0] do2;
   logic [15:0] imm;
   logic [3:0]  dest;
   logic [1:0]  alucnt;
   logic        sel;
   logic        wes;
   logic [7:0]  disp8;
   logic [7:0]  nxtadrsrr;
   logic [1:0]  branchs;
   logic        stall;

   int   passed = 0;
   int   total  = 0;
   out_t sb [$];
   vec_t tbl [$];
   out_t bub;

   always #5 clk = ~clk;

   decode_regfile dut (
      .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
      .instr_valid(instr_valid), .wdata_e(wdata_e),
      .dest_e(dest_e), .we_e(we_e), .bj(bj),
      .do1(do1), .do2(do2), .imm(imm), .dest(dest),
      .alucnt(alucnt), .sel(sel), .wes(wes), .disp8(disp8),
      .nxtadrsrr(nxtadrsrr), .branchs(branchs), .stall(stall)
   );

   function automatic out_t mo(
      logic [15:0] a, logic [15:0] b, logic [15:0] im,
      logic [3:0] d, logic [1:0] al, logic s, logic w,
      logic [7:0] ds, logic [7:0] nx, logic [1:0] br);
      out_t o;
      o.do1 = a; o.do2 = b; o.imm = im; o.dest = d;
      o.alucnt = al; o.sel = s; o.wes = w; o.disp8 = ds;
      o.nxt = nx; o.branchs = br;
      return o;
   endfunction

   function automatic vec_t mv(
      logic r, logic [15:0] in, logic [7:0] pc, logic v,
      logic we, logic [3:0] de, logic [15:0] wd, logic b,
      logic cs, logic st, out_t e);
      vec_t x;
      x.rst = r; x.instr = in; x.pc = pc; x.valid = v;
      x.we = we; x.de = de; x.wd = wd; x.bj = b;
      x.chk_stall = cs; x.stall = st; x.exp = e;
      return x;
   endfunction

   // One decode cycle: drive, check stall, queue expectation, compare.
   task automatic step(input vec_t v, input string nm);
      out_t got;
      out_t want;
      @(negedge clk);
      rst = v.rst; instr = v.instr; pc_in = v.pc;
      instr_valid = v.valid; we_e = v.we; dest_e = v.de;
      wdata_e = v.wd; bj = v.bj;
      #1;
      if (v.chk_stall) begin
         total++;
         if (stall === v.stall) passed++;
         else $display("FAIL %s stall got %b want %b",
                       nm, stall, v.stall);
      end
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      got = {do1, do2, imm, dest, alucnt, sel, wes,
             disp8, nxtadrsrr, branchs};
      want = sb.pop_front();
      total++;
      if (got === want) passed++;
      else $display("FAIL %s idex got %h want %h", nm, got, want);
   endtask

   initial begin
      bub = '0;
      rst = 1'b1; instr = '0; pc_in = '0; instr_valid = 1'b0;
      we_e = 1'b0; dest_e = '0; wdata_e = '0; bj = 1'b0;

      // reset for two cycles
      step(mv(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0, bub), "rst0");
      step(mv(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 1, 0, bub), "rst1");

      tbl.push_back(mv(0, 16'h435A, 8'h00, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h005A, 3, 0, 1, 1, 0, 8'h01, 0)));
      tbl.push_back(mv(0, 16'h0150, 8'h01, 1, 1, 5, 16'h1234, 0, 1, 0,
         mo(16'h1234, 0, 16'h0050, 1, 0, 0, 1, 0, 8'h02, 0)));
      tbl.push_back(mv(0, 16'h4207, 8'h02, 1, 1, 3, 16'h005A, 0, 1, 0,
         mo(0, 0, 16'h0007, 2, 0, 1, 1, 0, 8'h03, 0)));
      tbl.push_back(mv(0, 16'h1422, 8'h03, 1, 1, 1, 16'h1234, 0, 1, 1,
         bub));
      tbl.push_back(mv(0, 16'h1422, 8'h03, 1, 1, 2, 16'h0007, 0, 1, 0,
         mo(16'h0007, 16'h0007, 16'h0022, 4, 1, 0, 1, 0, 8'h04, 0)));
      tbl.push_back(mv(0, 16'h4009, 8'h04, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h0009, 0, 0, 1, 1, 0, 8'h05, 0)));
      tbl.push_back(mv(0, 16'h3100, 8'h05, 1, 1, 0, 16'h0009, 0, 1, 0,
         mo(0, 0, 16'h0000, 1, 3, 0, 1, 0, 8'h06, 0)));
      tbl.push_back(mv(0, 16'h3111, 8'h06, 0, 0, 0, 16'h0000, 0, 1, 0,
         bub));
      tbl.push_back(mv(0, 16'h811E, 8'h10, 1, 1, 1, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h001E, 0, 0, 0, 0, 8'hFE, 8'h11, 1)));
      tbl.push_back(mv(0, 16'h0655, 8'h11, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(16'h1234, 16'h1234, 16'h0055, 6, 0, 0, 1, 0, 8'h12, 0)));
      tbl.push_back(mv(0, 16'h1760, 8'h12, 1, 0, 0, 16'h0000, 1, 1, 0,
         bub));
      tbl.push_back(mv(0, 16'h4100, 8'hFF, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h0000, 1, 0, 1, 1, 0, 8'h00, 0)));
      tbl.push_back(mv(0, 16'hF123, 8'h20, 1, 0, 0, 16'h0000, 0, 1, 0,
         bub));
      tbl.push_back(mv(0, 16'hA247, 8'h30, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(16'h0007, 0, 16'h0047, 0, 0, 0, 0, 8'h07, 8'h31, 3)));
      tbl.push_back(mv(0, 16'h9338, 8'h40, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(16'h005A, 16'h005A, 16'h0038, 0, 0, 0, 0, 8'hF8, 8'h41, 2)));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // reset while a RAW stall is pending
      step(mv(0, 16'h4901, 8'h50, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h0001, 9, 0, 1, 1, 0, 8'h51, 0)), "li_r9");
      step(mv(1, 16'h1A90, 8'h51, 1, 0, 0, 16'h0000, 0, 1, 1,
         bub), "rst_stall");
      step(mv(0, 16'h0153, 8'h52, 1, 0, 0, 16'h0000, 0, 1, 0,
         mo(0, 0, 16'h0053, 1, 0, 0, 1, 0, 8'h53, 0)), "rf_clear");

      // reset while a squash is requested
      step(mv(1, 16'h1110, 8'h53, 1, 0, 0, 16'h0000, 1, 1, 0,
         bub), "rst_squash");
      step(mv(0, 16'h0000, 8'h54, 0, 0, 0, 16'h0000, 0, 1, 0,
         bub), "post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
